// File: rtl/fa_behav_pkg.sv
// Shared types and defaults for the behavioural full adder.
// The single-bit result struct and add function are used by fa_bit.
package fa_behav_pkg;

  localparam int FA_WIDTH = 1;
  localparam int FA_CNT_W = 16;

  typedef struct packed {
    logic                carry;
    logic [FA_WIDTH-1:0] sum;
  } fa_result_t;

  // Plain logic operators, so X/Z on an input reaches the result unmasked
  function automatic fa_result_t fa_add1(input logic a, input logic b, input logic ci);
    fa_result_t r;
    r.sum   = a ^ b ^ ci;
    r.carry = (a & b) | (a & ci) | (b & ci);
    return r;
  endfunction

endpackage

// File: rtl/fa_bit.sv
// One-bit combinational full adder cell; one link of the ripple chain.
module fa_bit
  import fa_behav_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  fa_result_t res;

  assign res = fa_add1(a, b, ci);
  assign s   = res.sum;
  assign co  = res.carry;

endmodule

// File: rtl/fa_behav.sv
// Ripple-carry adder built from fa_bit cells, with a registered copy of the result.
// Optional saturating carry-out counter when FA_BEHAV_STATS_EN is defined.
module fa_behav
  import fa_behav_pkg::*;
#(
  parameter int WIDTH = FA_WIDTH,
  parameter int CNT_W = FA_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_q
`ifdef FA_BEHAV_STATS_EN
  ,
  output logic [CNT_W-1:0] cout_cnt
`endif
);

  if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
    $error("fa_behav: WIDTH and CNT_W must be at least 1");
  end

  logic [WIDTH:0] cy;

  assign cy[0] = c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_bit u_bit (
      .a  (a[i]),
      .b  (b[i]),
      .ci (cy[i]),
      .s  (sum[i]),
      .co (cy[i+1])
    );
  end

  assign carry = cy[WIDTH];

  logic [WIDTH-1:0] sum_d;
  logic             carry_d;

  assign sum_d   = sum;
  assign carry_d = carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

`ifdef FA_BEHAV_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Holds at all-ones instead of wrapping
  always_comb begin
    cnt_d = cnt_q;
    if (carry && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cout_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fa_behav.sv
// Self-checking bench for fa_behav: a 1-bit and an 8-bit instance share clock and reset.
// Registered-path expectations go through scoreboard queues.
module tb_fa_behav;

  logic       clk, clk_en, rst;
  logic       a1, b1, c1, s1, co1, sq1, cq1;
  logic [7:0] a8, b8, s8, sq8;
  logic       c8, co8, cq8;
`ifdef FA_BEHAV_STATS_EN
  logic [15:0] cnt1;
  logic [1:0]  cnt8;
`endif

  int checks;
  int errors;

  logic [1:0] sb1_q[$];
  logic [8:0] sb8_q[$];

  fa_behav #(.WIDTH(1)) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .a       (a1),
    .b       (b1),
    .c       (c1),
    .sum     (s1),
    .carry   (co1),
    .sum_q   (sq1),
    .carry_q (cq1)
`ifdef FA_BEHAV_STATS_EN
    ,
    .cout_cnt(cnt1)
`endif
  );

  fa_behav #(.WIDTH(8), .CNT_W(2)) u_dut8 (
    .clk     (clk),
    .rst     (rst),
    .a       (a8),
    .b       (b8),
    .c       (c8),
    .sum     (s8),
    .carry   (co8),
    .sum_q   (sq8),
    .carry_q (cq8)
`ifdef FA_BEHAV_STATS_EN
    ,
    .cout_cnt(cnt8)
`endif
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({cq1, sq1} !== 2'b00) begin
      errors++; $display("FAIL reset_q1: got %b want 00", {cq1, sq1});
    end
    checks++;
    if ({cq8, sq8} !== 9'h000) begin
      errors++; $display("FAIL reset_q8: got %h want 000", {cq8, sq8});
    end
`ifdef FA_BEHAV_STATS_EN
    checks++;
    if (cnt8 !== 2'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d want 0", cnt8);
    end
`endif
  endtask

  // clk idle throughout: the combinational path alone
  task automatic test_exhaustive();
    logic [2:0] vb;
    logic [1:0] exp;
    for (int v = 0; v < 8; v++) begin
      vb = v[2:0];
      {a1, b1, c1} = vb;
      #10;
      exp = {1'b0, vb[2]} + {1'b0, vb[1]} + {1'b0, vb[0]};
      checks++;
      if ({co1, s1} !== exp) begin
        errors++; $display("FAIL exhaustive abc=%b: got %b want %b", vb, {co1, s1}, exp);
      end
    end
  endtask

  task automatic test_reset_release();
    logic [1:0] exp;
    rst = 1'b1;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({cq1, sq1} !== 2'b00) begin
      errors++; $display("FAIL held_in_reset: got %b want 00", {cq1, sq1});
    end
    @(negedge clk);
    rst = 1'b0;
    sb1_q.push_back(2'b11);
    @(posedge clk);
    #1;
    exp = sb1_q.pop_front();
    checks++;
    if ({cq1, sq1} !== exp) begin
      errors++; $display("FAIL first_capture: got %b want %b", {cq1, sq1}, exp);
    end
  endtask

  task automatic test_vectors8();
    logic [7:0] ta[4];
    logic [7:0] tb[4];
    logic       tc[4];
    logic [7:0] es[4];
    logic       ec[4];
    ta = '{8'hFF, 8'h5A, 8'hFF, 8'h00};
    tb = '{8'h00, 8'h33, 8'hFF, 8'h00};
    tc = '{1'b1,  1'b0,  1'b1,  1'b0};
    es = '{8'h00, 8'h8D, 8'hFF, 8'h00};
    ec = '{1'b1,  1'b0,  1'b1,  1'b0};
    for (int i = 0; i < 4; i++) begin
      a8 = ta[i]; b8 = tb[i]; c8 = tc[i];
      #1;
      checks++;
      if (s8 !== es[i]) begin
        errors++; $display("FAIL vec8_sum[%0d]: got %h want %h", i, s8, es[i]);
      end
      checks++;
      if (co8 !== ec[i]) begin
        errors++; $display("FAIL vec8_carry[%0d]: got %b want %b", i, co8, ec[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [1:0] exp;
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
    sb1_q.push_back(2'b01);
    @(posedge clk);
    #1;
    exp = sb1_q.pop_front();
    checks++;
    if ({cq1, sq1} !== exp) begin
      errors++; $display("FAIL pre_async_q: got %b want %b", {cq1, sq1}, exp);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (sq1 !== 1'b0) begin
      errors++; $display("FAIL async_clear: got %b want 0", sq1);
    end
    checks++;
    if ({co1, s1} !== 2'b01) begin
      errors++; $display("FAIL comb_during_rst: got %b want 01", {co1, s1});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

`ifdef FA_BEHAV_STATS_EN
  task automatic test_stats();
    logic [1:0] exp;
    @(negedge clk);
    rst = 1'b1;
    a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0;
    #1;
    checks++;
    if (cnt8 !== 2'd0) begin
      errors++; $display("FAIL stats_clear: got %0d want 0", cnt8);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      exp = (k > 3) ? 2'd3 : 2'(k);
      checks++;
      if (cnt8 !== exp) begin
        errors++; $display("FAIL stats_cnt[%0d]: got %0d want %0d", k, cnt8, exp);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (cnt8 !== 2'd0) begin
      errors++; $display("FAIL stats_rst: got %0d want 0", cnt8);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [8:0] exp;
    logic [8:0] got;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      c8 = 1'($urandom_range(0, 1));
      #1;
      exp = {1'b0, a8} + {1'b0, b8} + {8'h00, c8};
      checks++;
      if ({co8, s8} !== exp) begin
        errors++; $display("FAIL rand_comb[%0d]: got %h want %h", n, {co8, s8}, exp);
      end
      sb8_q.push_back(exp);
      @(posedge clk);
      #1;
      got = {cq8, sq8};
      checks++;
      if (sb8_q.size() == 0) begin
        errors++; $display("FAIL rand_sb_empty[%0d]: got empty want entry", n);
      end else begin
        exp = sb8_q.pop_front();
        if (got !== exp) begin
          errors++; $display("FAIL rand_reg[%0d]: got %h want %h", n, got, exp);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk_en = 1'b0;
    rst = 1'b0;
    a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
    #1;
    test_reset();
    test_exhaustive();
    test_reset_release();
    test_vectors8();
    test_async_reset();
`ifdef FA_BEHAV_STATS_EN
    test_stats();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
